fetch: RTL and testbench

FETCH -- requirements
Module: fetch

---
 rtl/fetch_pkg.sv | 28 ++
 rtl/fetch.sv | 135 +++++++++++++
 tb/tb_fetch.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: instruction encodings, reset/interrupt vectors,
// fetch FSM state type and the PC increment helper.
`ifndef INST_NOP
`define INST_NOP 32'h0000_0013
`endif
`ifndef INST_BNE_EXCEPT
`define INST_BNE_EXCEPT 32'h0000_1063
`endif

package fetch_pkg;

    localparam logic [31:0] RESET_VEC       = 32'h8000_0000;
    localparam logic [31:0] IRQ_VEC         = 32'h8000_0008;
    localparam logic [31:0] NOP_INSN        = `INST_NOP;
    localparam logic [31:0] BNE_EXCEPT_INSN = `INST_BNE_EXCEPT;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HELD  = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    // Bit 31 is the supervisor bit; the address part wraps within 2^31.
    function automatic logic [31:0] pc_next(input logic [31:0] a);
        return {a[31], a[30:0] + 31'd4};
    endfunction

endpackage

// File: rtl/fetch.sv
// Instruction fetch stage: one outstanding imem request, one-entry hold register,
// redirect with drain of stale responses. Interrupt entry is built only with FETCH_IRQ_EN.
module fetch
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        op_jmp,
    input  logic        op_beq,
    input  logic        op_bne,
    input  logic        zr,
    input  logic [31:0] j_addr,
    input  logic [31:0] br_addr,
`ifdef FETCH_IRQ_EN
    input  logic        irq,
`endif
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] ir
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_f_q, pc_f_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  ir_q, ir_d;
    logic [31:0]  hold_q, hold_d;
    logic         first_q, first_d;

    logic         taken;
    logic         irq_take;
    logic         ack_v;
    logic         outstanding;
    logic [31:0]  br_tgt;
    logic [31:0]  j_tgt;
    logic [31:0]  tgt;
    logic [31:0]  pc_f_inc;
    logic         unused_addr_bits;

    assign unused_addr_bits = ^{j_addr[1:0], br_addr[31], br_addr[1:0]};

    assign taken  = op_jmp | (op_beq & zr) | (op_bne & ~zr);
    // A branch keeps the supervisor bit; a jump can only clear it.
    assign br_tgt = {pc_f_q[31], br_addr[30:2], 2'b00};
    assign j_tgt  = {pc_f_q[31] & j_addr[31], j_addr[30:2], 2'b00};
    assign tgt    = op_jmp ? j_tgt : br_tgt;

`ifdef FETCH_IRQ_EN
    assign irq_take = irq & ~pc_f_q[31] & ~stall & ~taken;
`else
    assign irq_take = 1'b0;
`endif

    // An ack in the first cycle after reset belongs to an abandoned access.
    assign ack_v       = imem_ack & ~first_q;
    assign outstanding = (state_q != ST_HELD) & ~ack_v;
    assign pc_f_inc    = pc_next(pc_f_q);

    assign imem_req  = (state_q == ST_FETCH);
    assign imem_addr = pc_f_q;
    assign pc        = pc_q;
    assign ir        = ir_q;

    always_comb begin
        state_d = state_q;
        pc_f_d  = pc_f_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        hold_d  = hold_q;
        first_d = 1'b0;
        if (stall) begin
            if (ack_v && state_q == ST_FETCH) begin
                hold_d  = imem_rdata;
                state_d = ST_HELD;
            end else if (ack_v && state_q == ST_DRAIN) begin
                state_d = ST_FETCH;
            end
        end else if (taken || irq_take) begin
            pc_f_d  = taken ? tgt : IRQ_VEC;
            ir_d    = taken ? NOP_INSN : BNE_EXCEPT_INSN;
            if (irq_take) begin
                pc_d = pc_f_inc;
            end
            state_d = outstanding ? ST_DRAIN : ST_FETCH;
        end else begin
            ir_d = NOP_INSN;
            case (state_q)
                ST_FETCH: begin
                    if (ack_v) begin
                        ir_d   = imem_rdata;
                        pc_d   = pc_f_inc;
                        pc_f_d = pc_f_inc;
                    end
                end
                ST_HELD: begin
                    ir_d    = hold_q;
                    pc_d    = pc_f_inc;
                    pc_f_d  = pc_f_inc;
                    state_d = ST_FETCH;
                end
                ST_DRAIN: begin
                    if (ack_v) begin
                        state_d = ST_FETCH;
                    end
                end
                default: state_d = ST_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FETCH;
            pc_f_q  <= RESET_VEC;
            pc_q    <= RESET_VEC;
            ir_q    <= NOP_INSN;
            first_q <= 1'b1;
        end else begin
            state_q <= state_d;
            pc_f_q  <= pc_f_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            first_q <= first_d;
        end
    end

    // Hold data is qualified by the HELD state, so it needs no reset.
    always_ff @(posedge clk) begin
        hold_q <= hold_d;
    end

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: variable-latency instruction memory plus a transaction-level model
// of delivered instructions. Define FETCH_IRQ_EN to also cover interrupt entry.
module tb_fetch;
    import fetch_pkg::*;

`ifdef FETCH_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        op_jmp = 1'b0;
    logic        op_beq = 1'b0;
    logic        op_bne = 1'b0;
    logic        zr = 1'b0;
    logic        irq = 1'b0;
    logic [31:0] j_addr = 32'h0;
    logic [31:0] br_addr = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] pc;
    logic [31:0] ir;

    fetch dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .op_jmp     (op_jmp),
        .op_beq     (op_beq),
        .op_bne     (op_bne),
        .zr         (zr),
        .j_addr     (j_addr),
        .br_addr    (br_addr),
`ifdef FETCH_IRQ_EN
        .irq        (irq),
`endif
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .pc         (pc),
        .ir         (ir)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%08h want=%08h", tag, got, want);
        end
    endtask

    // Memory and reference-model state
    logic [31:0] exp_addr = 32'h8000_0000;
    logic [31:0] e_ir = 32'h0;
    logic [31:0] e_pc = 32'h8000_0000;
    logic [31:0] maddr = 32'h0;
    logic [31:0] beef_addr = 32'h1;
    int          gen = 0;
    int          mgen = 0;
    int          mcnt = 0;
    int          lat = 1;
    int          ndeliv = 0;
    int          gap = 0;
    int          maxgap = 0;
    bit          mbusy = 1'b0;
    bit          have = 1'b0;
    bit          force_ack = 1'b0;
    bit          track_gap = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == beef_addr) return 32'hDEAD_BEEF;
        return {~a[15:0], a[31:16]} ^ 32'h1;
    endfunction

    function automatic logic [31:0] inc4(input logic [31:0] a);
        return {a[31], a[30:0] + 31'd4};
    endfunction

    task automatic tick();
        bit          busy0;
        bit          ack_n;
        bit          ok_n;
        bit          tk;
        bit          irqc;
        bit          progress;
        logic [31:0] tgt;
        busy0 = mbusy;
        ack_n = 1'b0;
        ok_n  = 1'b0;
        if (force_ack) begin
            ack_n     = 1'b1;
            force_ack = 1'b0;
        end else if (mbusy) begin
            mcnt--;
            if (mcnt == 0) begin
                ack_n = 1'b1;
                ok_n  = (mgen == gen);
                mbusy = 1'b0;
            end
        end
        imem_ack   = ack_n;
        imem_rdata = ack_n ? (busy0 ? mem_word(maddr) : 32'hBAD0_0000) : $urandom;
        #1;
        if (imem_req) begin
            check("req_addr", imem_addr, exp_addr);
            if (busy0 && !ack_n) check("addr_hold", imem_addr, maddr);
            if (!busy0) begin
                mbusy = 1'b1;
                maddr = imem_addr;
                mgen  = gen;
                mcnt  = lat;
            end
        end
        tk   = op_jmp | (op_beq & zr) | (op_bne & ~zr);
        tgt  = op_jmp ? {exp_addr[31] & j_addr[31], j_addr[30:2], 2'b00}
                      : {exp_addr[31], br_addr[30:2], 2'b00};
        irqc = IRQ_EN && irq && !exp_addr[31];
        progress = 1'b0;
        if (ack_n && ok_n) have = 1'b1;
        if (!stall) begin
            if (tk) begin
                e_ir = NOP_INSN; exp_addr = tgt; have = 1'b0; gen++; progress = 1'b1;
            end else if (irqc) begin
                e_ir = BNE_EXCEPT_INSN; e_pc = inc4(exp_addr); exp_addr = 32'h8000_0008;
                have = 1'b0; gen++; progress = 1'b1;
            end else if (have) begin
                e_ir = mem_word(exp_addr); e_pc = inc4(exp_addr); exp_addr = e_pc;
                have = 1'b0; ndeliv++; progress = 1'b1;
            end else begin
                e_ir = NOP_INSN;
            end
            gap = progress ? 0 : gap + 1;
            if (track_gap && gap > maxgap) maxgap = gap;
        end
        @(posedge clk);
        #1;
        imem_ack = 1'b0;
        check("ir", ir, e_ir);
        check("pc", pc, e_pc);
    endtask

    task automatic do_reset(input bit fack);
        rst = 1'b1;
        #1;
        check("rst_ir", ir, NOP_INSN);
        check("rst_pc", pc, 32'h8000_0000);
        check("rst_addr", imem_addr, 32'h8000_0000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_req", {31'h0, imem_req}, 32'h1);
        exp_addr  = 32'h8000_0000;
        e_ir      = NOP_INSN;
        e_pc      = 32'h8000_0000;
        have      = 1'b0;
        gen++;
        mbusy     = 1'b0;
        force_ack = fack;
        gap       = 0;
    endtask

    task automatic clear_ops();
        op_jmp = 1'b0; op_beq = 1'b0; op_bne = 1'b0; zr = 1'b0; irq = 1'b0; stall = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        for (int i = 0; i < 20 && !imem_req; i++) tick();
        if (!imem_req) check(tag, 32'h0, 32'h1);
    endtask

    task automatic wait_deliv(input string tag);
        int n0;
        n0 = ndeliv;
        for (int i = 0; i < 30 && ndeliv == n0; i++) tick();
        if (ndeliv == n0) check(tag, 32'h0, 32'h1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] saved;
        #2;
        // Reset release with 1-cycle memory
        lat = 1;
        do_reset(1'b0);
        check("r28_addr0", imem_addr, 32'h8000_0000);
        tick();
        tick();
        check("r28_ir0", ir, mem_word(32'h8000_0000));
        check("r28_pc0", pc, 32'h8000_0004);
        check("r28_addr1", imem_addr, 32'h8000_0004);
        tick();
        tick();
        check("r28_pc1", pc, 32'h8000_0008);

        // Stall across the ack of 0xDEADBEEF
        lat = 3;
        beef_addr = 32'h8000_0008;
        for (int i = 0; i < 20 && !(mbusy && maddr == beef_addr && mcnt == 1); i++) tick();
        if (!(mbusy && maddr == beef_addr && mcnt == 1)) check("r29_setup", 32'h0, 32'h1);
        saved = e_ir;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("r29_hold", ir, saved);
        end
        stall = 1'b0;
        tick();
        check("r29_beef", ir, 32'hDEAD_BEEF);
        check("r29_pc", pc, 32'h8000_000C);
        tick();
        check("r29_nodup", ir, NOP_INSN);

        // Taken BEQ from 0x8000_0010 with an unacked request in flight
        for (int i = 0; i < 30 && exp_addr != 32'h8000_0010; i++) tick();
        check("r30_pcf", exp_addr, 32'h8000_0010);
        op_beq = 1'b1; zr = 1'b1; br_addr = 32'h0000_0100;
        tick();
        clear_ops();
        check("r30_nop", ir, NOP_INSN);
        check("r32_drain", {31'h0, imem_req}, 32'h0);
        wait_req("r30_req_timeout");
        check("r30_addr", imem_addr, 32'h8000_0100);
        wait_deliv("r32_deliv_timeout");
        check("r32_first", ir, mem_word(32'h8000_0100));

        // Jumps: supervisor bit may be cleared but never set
        lat = 1;
        op_jmp = 1'b1; j_addr = 32'h0000_0200;
        tick();
        clear_ops();
        wait_req("r31_req0_timeout");
        check("r31_t0", imem_addr, 32'h0000_0200);
        op_jmp = 1'b1; j_addr = 32'h8000_0040;
        tick();
        clear_ops();
        wait_req("r31_req1_timeout");
        check("r31_t1", imem_addr, 32'h0000_0040);

`ifdef FETCH_IRQ_EN
        // Interrupt in user mode, then ignored in supervisor mode
        irq = 1'b1;
        tick();
        irq = 1'b0;
        check("r33_ir", ir, BNE_EXCEPT_INSN);
        check("r33_pc", pc, 32'h0000_0044);
        wait_req("r33_req_timeout");
        check("r33_vec", imem_addr, 32'h8000_0008);
        irq = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("r33_sup", {31'h0, ir == BNE_EXCEPT_INSN}, 32'h0);
        end
        irq = 1'b0;
`endif

        // Reset mid-request; a stray ack right after release must be ignored
        lat = 3;
        tick();
        do_reset(1'b1);
        wait_deliv("r23_deliv_timeout");
        check("r23_first", ir, mem_word(32'h8000_0000));

        // Randomized traffic
        track_gap = 1'b1;
        maxgap = 0;
        begin
            int n0;
            int r;
            n0 = ndeliv;
            for (int i = 0; i < 3000; i++) begin
                stall   = ($urandom % 100) < 30;
                r       = int'($urandom % 100);
                op_jmp  = (r < 4);
                op_beq  = (r >= 4 && r < 8);
                op_bne  = (r >= 8 && r < 12);
                zr      = (($urandom & 32'd1) != 0);
                j_addr  = $urandom;
                br_addr = $urandom;
                irq     = ($urandom % 100) < 5;
                lat     = 1 + int'($urandom % 3);
                tick();
            end
            clear_ops();
            track_gap = 1'b0;
            check("rand_progress", {31'h0, maxgap <= 10}, 32'h1);
            check("rand_deliveries", {31'h0, (ndeliv - n0) > 100}, 32'h1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
